// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel-enable, sync/active/coordinate generator with pipelined sync outputs
// Optional colour-bar output enabled by VGA_TIMING_PATTERN_EN.
module vga_timing_gen #(
  parameter int CE_DIV      = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480,
  parameter int PIPE_DLY    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_ce,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [11:0] test_rgb
`endif
);
  localparam logic [7:0] CE_LAST = 8'(CE_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS      = 10'(H_SYNC);
  localparam logic [9:0] VS      = 10'(V_SYNC);
  localparam logic [9:0] HAS     = 10'(H_ACT_START);
  localparam logic [9:0] HAE     = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] VAS     = 10'(V_ACT_START);
  localparam logic [9:0] VAE     = 10'(V_ACT_START + V_ACT);
`ifdef VGA_TIMING_PATTERN_EN
  localparam int DW = 15;
  localparam logic [DW-1:0] RST_WORD = {3'b110, 12'h000};
`else
  localparam int DW = 3;
  localparam logic [DW-1:0] RST_WORD = 3'b110;
`endif
  logic [7:0] ce_cnt;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic tick, act_nxt, hs_raw, vs_raw, act_raw;
  logic [DW-1:0] raw, dly;
  always_comb begin
    tick    = ce_cnt == CE_LAST;
    h_nxt   = h_cnt == H_LAST ? 10'd0 : h_cnt + 10'd1;
    v_nxt   = h_cnt != H_LAST ? v_cnt : v_cnt == V_LAST ? 10'd0 : v_cnt + 10'd1;
    act_nxt = h_nxt >= HAS && h_nxt < HAE && v_nxt >= VAS && v_nxt < VAE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt      <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_ce      <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      act_raw     <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ce_cnt      <= tick ? 8'd0 : ce_cnt + 8'd1;
      pix_ce      <= tick;
      line_start  <= tick && h_nxt == 10'd0;
      frame_start <= tick && h_nxt == 10'd0 && v_nxt == 10'd0;
      if (tick) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        hs_raw  <= h_nxt >= HS;
        vs_raw  <= v_nxt >= VS;
        act_raw <= act_nxt;
        x_pos   <= act_nxt ? h_nxt - HAS : 10'd0;
        y_pos   <= act_nxt ? v_nxt - VAS : 10'd0;
      end
    end
  end
`ifdef VGA_TIMING_PATTERN_EN
  // Bars are derived from the undelayed x_pos and ride the same delay line as active
  logic [11:0] bar;
  always_comb
    bar = x_pos < 10'd80  ? 12'hFFF : x_pos < 10'd160 ? 12'hFF0 :
          x_pos < 10'd240 ? 12'h0FF : x_pos < 10'd320 ? 12'h0F0 :
          x_pos < 10'd400 ? 12'hF0F : x_pos < 10'd480 ? 12'hF00 :
          x_pos < 10'd560 ? 12'h00F : 12'h000;
  assign raw = {hs_raw, vs_raw, act_raw, act_raw ? bar : 12'h000};
  assign test_rgb = dly[12] ? dly[11:0] : 12'h000;
`else
  assign raw = {hs_raw, vs_raw, act_raw};
`endif
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly = raw;
    end else begin : g_dly
      logic [DW-1:0] sr [PIPE_DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) sr[i] <= RST_WORD;
        end else if (tick) begin
          sr[0] <= raw;
          for (int i = 1; i < PIPE_DLY; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly = sr[PIPE_DLY-1];
    end
  endgenerate
  assign hsync  = dly[DW-1];
  assign vsync  = dly[DW-2];
  assign active = dly[DW-3];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scaled-geometry bench comparing PIPE_DLY=0 and PIPE_DLY=2 instances against an arithmetic model
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int CE = 4, HT = 40, HS = 6, HAS = 9, HA = 24, VT = 12, VS = 2, VAS = 4, VA = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic pc0, hs0, vs0, ac0, ls0, fs0, pc2, hs2, vs2, ac2, ls2, fs2;
  logic [9:0] x0, y0, x2, y2;
`ifdef VGA_TIMING_PATTERN_EN
  logic [11:0] rgb0, rgb2;
`endif
  vga_timing_gen #(.CE_DIV(CE), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA), .PIPE_DLY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pc0), .hsync(hs0), .vsync(vs0), .active(ac0),
    .x_pos(x0), .y_pos(y0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_PATTERN_EN
    , .test_rgb(rgb0)
`endif
  );
  vga_timing_gen #(.CE_DIV(CE), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA), .PIPE_DLY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .pix_ce(pc2), .hsync(hs2), .vsync(vs2), .active(ac2),
    .x_pos(x2), .y_pos(y2), .line_start(ls2), .frame_start(fs2)
`ifdef VGA_TIMING_PATTERN_EN
    , .test_rgb(rgb2)
`endif
  );
  int tests = 0, fails = 0, c = 0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  function automatic logic in_act(input int h, input int v);
    return h >= HAS && h < HAS + HA && v >= VAS && v < VAS + VA;
  endfunction
  // Expected outputs after c clock edges since reset release, for delay d
  function automatic logic [25:0] model(input int cc, input int d);
    int k = cc / CE;
    int kd = k - d;
    int h = k % HT;
    int v = (k / HT) % VT;
    int hd = kd % HT;
    int vd = (kd / HT) % VT;
    logic pix = cc > 0 && cc % CE == 0;
    logic a = k > 0 && in_act(h, v);
    logic [2:0] r = kd <= 0 ? 3'b110 : {hd >= HS, vd >= VS, in_act(hd, vd)};
    logic [9:0] x = a ? 10'(h - HAS) : 10'd0;
    logic [9:0] y = a ? 10'(v - VAS) : 10'd0;
    logic ls = pix && h == 0;
    return {pix, r, x, y, ls, ls && v == 0};
  endfunction
  function automatic logic [11:0] exp_rgb(input int cc, input int d);
    logic [11:0] tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int kd = cc / CE - d;
    int hd = kd % HT;
    int vd = (kd / HT) % VT;
    return (kd > 0 && in_act(hd, vd)) ? tbl[(hd - HAS) / 80] : 12'h000;
  endfunction
  always @(posedge clk) begin
    #1;
    c = rst_n ? c + 1 : 0;
    chk("cyc_d0", {pc0, hs0, vs0, ac0, x0, y0, ls0, fs0}, model(c, 0));
    chk("cyc_d2", {pc2, hs2, vs2, ac2, x2, y2, ls2, fs2}, model(c, 2));
`ifdef VGA_TIMING_PATTERN_EN
    chk("rgb_d0", rgb0, exp_rgb(c, 0));
    chk("rgb_d2", rgb2, exp_rgb(c, 2));
`endif
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic async_rst_check();
    #1;
    chk("async_rst_d0", {pc0, hs0, vs0, ac0, x0, y0, ls0, fs0}, {1'b0, 3'b110, 22'd0});
    chk("async_rst_d2", {pc2, hs2, vs2, ac2, x2, y2, ls2, fs2}, {1'b0, 3'b110, 22'd0});
  endtask
  int e, np, nl, nf, na, nh0, nv0, nh2, f0, f2, xm, ym;
  initial begin
    chk("model_last_px", model(392 * CE, 0), {1'b1, 3'b111, 10'd23, 10'd5, 2'b00});
    chk("model_after_last", model(393 * CE, 0), {1'b1, 3'b110, 10'd0, 10'd0, 2'b00});
    chk("model_frame_d0", model(480 * CE, 0), {1'b1, 3'b000, 10'd0, 10'd0, 2'b11});
    chk("model_frame_d2", model(480 * CE, 2), {1'b1, 3'b110, 10'd0, 10'd0, 2'b11});
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("first_ce", pc0, i == 4);
    end
    e = 4;
    while (!fs0 && e < 4000) begin
      step();
      e++;
    end
    chk("first_frame_edge", e, 1920);
    {np, nl, nf, na, nh0, nv0, nh2, xm, ym} = '0;
    f0 = -1;
    f2 = -1;
    for (int i = 0; i < HT * VT * CE; i++) begin
      if (i != 0) step();
      np += pc0;
      nl += ls0;
      nf += fs0;
      na += int'(pc0 && ac0);
      nh0 += int'(pc0 && !hs0);
      nv0 += int'(pc0 && !vs0);
      nh2 += int'(pc2 && !hs2);
      if (!hs0 && f0 < 0) f0 = i;
      if (!hs2 && f2 < 0) f2 = i;
      if (int'(x0) > xm) xm = int'(x0);
      if (int'(y0) > ym) ym = int'(y0);
    end
    chk("frame_pix_ce", np, 480);
    chk("frame_lines", nl, 12);
    chk("frame_starts", nf, 1);
    chk("frame_active", na, 144);
    chk("hsync_low_d0", nh0, 72);
    chk("vsync_low_d0", nv0, 80);
    chk("hsync_low_d2", nh2, 72);
    chk("hsync_fall_d0", f0, 0);
    chk("hsync_shift", f2 - f0, 8);
    chk("x_max", xm, 23);
    chk("y_max", ym, 5);
    repeat (6) begin
      repeat ($urandom_range(50, 3000)) step();
      #($urandom_range(1, 7));
      rst_n = 1'b0;
      async_rst_check();
      repeat ($urandom_range(1, 4)) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
    end
    repeat ((7 * HT + 20) * CE) step();
    #3;
    rst_n = 1'b0;
    async_rst_check();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    e = 0;
    do begin
      step();
      e++;
    end while (!fs0 && e < 4000);
    chk("post_rst_frame", e, 1920);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
